// File: rtl/pc_pkg.sv
// pc_pkg: shared PC mux selection codes, sequencer state encoding and PC reset value.
package pc_pkg;
   localparam logic [1:0] SEL_NEXT   = 2'b00;
   localparam logic [1:0] SEL_FIRST  = 2'b01;
   localparam logic [1:0] SEL_ZERO   = 2'b10;
   localparam logic [1:0] SEL_BRANCH = 2'b11;
   localparam logic [31:0] PC_RESET_VAL = 32'h20;
   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      DRAIN    = 2'd2,
      INT_JUMP = 2'd3
   } state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: sequencer <-> PC mux/pipeline signal bundle; PCSEQ_IRQ_MASK_EN adds irq_mask.
interface pc_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] pc_in;
   logic              inst_is_32;
   logic              boot_valid;
   logic              stall;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_addr;
   logic              irq;
`ifdef PCSEQ_IRQ_MASK_EN
   logic              irq_mask;
`endif
   logic [1:0]        selection;
   logic              pc_enable;
   logic [ADDR_W-1:0] next_instruction_addr;
   logic              flush;
   logic              irq_ack;
   logic [ADDR_W-1:0] int_ret_addr;
   modport master (
      input  pc_in, inst_is_32, boot_valid, stall, branch_taken, branch_addr, irq,
`ifdef PCSEQ_IRQ_MASK_EN
      input  irq_mask,
`endif
      output selection, pc_enable, next_instruction_addr, flush, irq_ack, int_ret_addr
   );
   modport slave (
      output pc_in, inst_is_32, boot_valid, stall, branch_taken, branch_addr, irq,
`ifdef PCSEQ_IRQ_MASK_EN
      output irq_mask,
`endif
      input  selection, pc_enable, next_instruction_addr, flush, irq_ack, int_ret_addr
   );
endinterface

// File: rtl/pc_incr.sv
// pc_incr: next sequential address, +1 for 16-bit and +2 for 32-bit instructions (wraps).
module pc_incr #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              two,
   output logic [ADDR_W-1:0] next
);
   assign next = pc + ADDR_W'(two ? 2 : 1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC mux control for boot, fetch, branch, stall and interrupt entry with drain.
// Build option PCSEQ_IRQ_MASK_EN adds irq_mask, which holds off interrupt acceptance in RUN.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DRAIN_CYCLES = 3
) (
   input logic            clk,
   input logic            rst,
   pc_sequencer_if.master bus
);
   localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);
   state_t            state, state_n;
   logic [3:0]        cnt, cnt_n;
   logic              pending, pending_n;
   logic [ADDR_W-1:0] ret, ret_n;
   logic [1:0]        sel;
   logic              en, fl, ack, irq_open;
`ifdef PCSEQ_IRQ_MASK_EN
   assign irq_open = !bus.irq_mask;
`else
   assign irq_open = 1'b1;
`endif
   pc_incr #(.ADDR_W(ADDR_W)) u_incr (
      .pc   (bus.pc_in),
      .two  (bus.inst_is_32),
      .next (bus.next_instruction_addr)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= BOOT;
         cnt     <= '0;
         pending <= 1'b0;
         ret     <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         pending <= pending_n;
         ret     <= ret_n;
      end
   end
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      ret_n     = ret;
      pending_n = pending | bus.irq;
      sel       = SEL_NEXT;
      en        = 1'b0;
      fl        = 1'b0;
      ack       = 1'b0;
      case (state)
         BOOT: begin
            if (bus.boot_valid) begin
               sel     = SEL_FIRST;
               en      = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            if (bus.branch_taken) begin
               sel = SEL_BRANCH;
               en  = 1'b1;
            end else if (pending && !bus.stall && irq_open) begin
               fl      = 1'b1;
               ret_n   = bus.pc_in;
               cnt_n   = DRAIN_LOAD;
               state_n = (DRAIN_CYCLES == 0) ? INT_JUMP : DRAIN;
            end else begin
               en = !bus.stall;
            end
         end
         DRAIN: begin
            // an older branch resolving now redirects where the handler returns to
            ret_n   = bus.branch_taken ? bus.branch_addr : ret;
            cnt_n   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
            state_n = (cnt == 4'd0) ? INT_JUMP : DRAIN;
         end
         INT_JUMP: begin
            sel       = SEL_ZERO;
            en        = 1'b1;
            ack       = 1'b1;
            pending_n = 1'b0;
            state_n   = RUN;
         end
         default: state_n = BOOT;
      endcase
   end
   assign bus.selection    = rst ? sel : SEL_NEXT;
   assign bus.pc_enable    = rst & en;
   assign bus.flush        = rst & fl;
   assign bus.irq_ack      = rst & ack;
   assign bus.int_ret_addr = ret;
endmodule
